usb_host_xfer: RTL
==================

# usb_host_xfer

Host-side USB 2.0 transaction engine: the initiator counterpart of the device protocol stack. It accepts one transaction request (SETUP, OUT or IN) and drives the token and data encoder. It then collects the device's handshake or data packet from the decoder, returns an ACK for good IN data, and reports a result code. It sits between a host-level transfer scheduler and the shared `encode_packet`/`decode_packet` pair, with the encoder instanced with `TOKEN(1)`.

## Interface
- TIMEOUT, 48: response wait limit in clock cycles (bus turnaround plus packet start).
- CNT_BITS, $clog2(TIMEOUT+1): width of the timeout counter.
- clock  in  1  system clock (ULPI 60 MHz domain).
- reset  in  1  reset, synchronous, active-high.
- xfer_start_i  in  1  request strobe; sampled only in IDLE.
- xfer_type_i  in  2  token type (PID[3:2]): 00 OUT, 10 IN, 11 SETUP; 01 (SOF) is ignored.
- xfer_addr_i  in  7  device address.
- xfer_endp_i  in  4  endpoint number.
- xfer_toggle_i  in  1  DATA toggle: sent for OUT, expected for IN.
- xfer_busy_o  out  1  transaction in progress.
- xfer_done_o  out  1  one-cycle completion strobe.
- xfer_result_o  out  3  0 ACK/OK, 1 NAK, 2 STALL, 3 NYET, 4 TIMEOUT, 5 CRC, 6 TOGGLE, 7 PROTOCOL; held until the next done.
- tok_send_o  out  1  token request to the encoder.
- tok_done_i  in  1  token sent.
- tok_type_o  out  2  token type.
- tok_data_o  out  16  {5'b0, endp, addr}; the encoder appends CRC5.
- trn_tsend_o  out  1  data-packet request.
- trn_ttype_o  out  2  data PID[3:2]: 00 DATA0, 10 DATA1.
- trn_tdone_i  in  1  data packet sent.
- hsk_send_o  out  1  handshake request.
- hsk_type_o  out  2  always 00 (ACK).
- hsk_sent_i  in  1  handshake sent.
- hsk_recv_i  in  1  handshake received strobe.
- hsk_type_i  in  2  received handshake: 00 ACK, 10 NAK, 11 STALL, 01 NYET.
- usb_recv_i  in  1  end-of-data-packet strobe.
- usb_type_i  in  2  received data PID[3:2].
- crc_err_i  in  1  CRC16 error; valid with usb_recv_i.
- s_tvalid/s_tready/s_tlast/s_tdata  in/out/in/in  1/1/1/8  OUT/SETUP payload from the scheduler.
- enc_tvalid/enc_tready/enc_tlast/enc_tdata  out/in/out/out  1/1/1/8  payload to the encoder.
- dec_tvalid/dec_tready/dec_tlast/dec_tdata  in/out/in/in  1/1/1/8  IN payload from the decoder.
- m_tvalid/m_tready/m_tlast/m_tdata  out/in/out/out  1/1/1/8  IN payload to the scheduler.

## Operation
- States: IDLE, TOKEN, DATA_TX, WAIT_HSK, WAIT_DATA, SEND_ACK, DONE.
- IDLE, on xfer_start_i with a type other than 01:
  - latch type, addr, endp and toggle;
  - go to TOKEN.
  - Type 01 is ignored and the block stays in IDLE.
- TOKEN:
  - tok_send_o is held high until tok_done_i.
  - On tok_done_i: IN goes to WAIT_DATA; OUT and SETUP go to DATA_TX.
- DATA_TX:
  - trn_tsend_o is held high until trn_tdone_i.
  - SETUP always uses DATA0; OUT uses DATA(toggle).
  - The s_ stream is wired to enc_ only in this state; s_tready=0 otherwise.
  - On trn_tdone_i, go to WAIT_HSK.
- WAIT_HSK:
  - On hsk_recv_i, result = hsk_type_i mapping (ACK 0, NAK 1, STALL 2, NYET 3); go to DONE.
  - On usb_recv_i, result = 7; go to DONE.
  - SETUP answered with NAK/STALL/NYET is reported as received; no retry is made here.
- WAIT_DATA:
  - The dec_ stream is wired to m_ only in this state; dec_tready=1 (discard) otherwise.
  - On usb_recv_i with crc_err_i, result = 5; go to DONE with no ACK.
  - On usb_recv_i without error, PID DATA(toggle) gives result 0; any other PID gives result 6. Both go to SEND_ACK.
  - On hsk_recv_i with NAK or STALL, result is 1 or 2; go to DONE. ACK or NYET gives result 7.
- SEND_ACK: hsk_send_o is held high until hsk_sent_i, then go to DONE.
- DONE: xfer_done_o=1 for one cycle, then return to IDLE.
- Timeout counter:
  - cleared on entry to WAIT_HSK or WAIT_DATA;
  - increments each cycle in those states;
  - at TIMEOUT, result = 4 and go to DONE.
  - A response strobe in the same cycle as expiry wins over the timeout.
- Unsolicited hsk_recv_i or usb_recv_i in IDLE, TOKEN, DATA_TX or SEND_ACK is ignored.

## Timing
- Reset values: state IDLE; busy, done, tok_send, trn_tsend, hsk_send, s_tready and m_tvalid all 0; result 0; dec_tready 1.
- All control outputs are registered; stream paths are combinational muxes selected by registered state.
- xfer_busy_o rises one cycle after the accepted xfer_start_i and falls in the cycle xfer_done_o is asserted.
- tok_send_o rises one cycle after start.
- Each send request drops the cycle after its done input.
- Minimum IN latency from tok_done_i to xfer_done_o: response time + 1 + ACK time + 1.
- Reset mid-transaction returns to IDLE next cycle without a done strobe; any partial stream is abandoned.

## Test plan
- OUT, addr 0x05, endp 1, toggle 1, 4 bytes, device ACK → tok_type 00, tok_data 0x0085, trn_ttype 10, 4 bytes with tlast on the 4th, result 0.
- SETUP with toggle 1, 8 bytes, device STALL → trn_ttype 00, result 2, done for exactly one cycle.
- IN, toggle 0, device sends DATA0 with 3 bytes → m_ sees 3 bytes, hsk_send with type 00, result 0. Repeat with DATA1 → ACK still sent, result 6.
- IN with crc_err_i=1 → no hsk_send, result 5. IN answered with NAK → result 1.
- No response, TIMEOUT=48 → done exactly 48 cycles after entering WAIT_HSK, result 4. Response strobe on cycle 48 → handshake result reported instead.
- Reset asserted in DATA_TX → IDLE, all outputs at reset values, no done. xfer_start_i while busy → ignored.

Source files
------------

// File: rtl/usb_host_xfer_if.sv
// Scheduler-side request/result bundle for the host transaction engine.
// The master is the transfer scheduler; the slave is usb_host_xfer.
interface usb_host_xfer_if;
    logic       xfer_start_i;
    logic [1:0] xfer_type_i;
    logic [6:0] xfer_addr_i;
    logic [3:0] xfer_endp_i;
    logic       xfer_toggle_i;
    logic       xfer_busy_o;
    logic       xfer_done_o;
    logic [2:0] xfer_result_o;

    modport master (
        output xfer_start_i, xfer_type_i, xfer_addr_i, xfer_endp_i, xfer_toggle_i,
        input  xfer_busy_o, xfer_done_o, xfer_result_o
    );

    modport slave (
        input  xfer_start_i, xfer_type_i, xfer_addr_i, xfer_endp_i, xfer_toggle_i,
        output xfer_busy_o, xfer_done_o, xfer_result_o
    );
endinterface

// File: rtl/usb_host_xfer.sv
// Host-side USB 2.0 transaction engine: issues one SETUP/OUT/IN transaction
// through the shared token/data encoder, collects the device response from
// the decoder, ACKs good IN data and reports a result code.
module usb_host_xfer #(
    parameter int TIMEOUT  = 48,
    parameter int CNT_BITS = $clog2(TIMEOUT + 1)
) (
    input  logic        clock,
    input  logic        reset,
    usb_host_xfer_if.slave xfer,

    output logic        tok_send_o,
    input  logic        tok_done_i,
    output logic [1:0]  tok_type_o,
    output logic [15:0] tok_data_o,

    output logic        trn_tsend_o,
    output logic [1:0]  trn_ttype_o,
    input  logic        trn_tdone_i,

    output logic        hsk_send_o,
    output logic [1:0]  hsk_type_o,
    input  logic        hsk_sent_i,
    input  logic        hsk_recv_i,
    input  logic [1:0]  hsk_type_i,

    input  logic        usb_recv_i,
    input  logic [1:0]  usb_type_i,
    input  logic        crc_err_i,

    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    input  logic [7:0]  s_tdata,

    output logic        enc_tvalid,
    input  logic        enc_tready,
    output logic        enc_tlast,
    output logic [7:0]  enc_tdata,

    input  logic        dec_tvalid,
    output logic        dec_tready,
    input  logic        dec_tlast,
    input  logic [7:0]  dec_tdata,

    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [7:0]  m_tdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOKEN,
        S_DATA_TX,
        S_WAIT_HSK,
        S_WAIT_DATA,
        S_SEND_ACK,
        S_DONE
    } state_t;

    // Token PID[3:2] values
    localparam logic [1:0] PID_OUT   = 2'b00;
    localparam logic [1:0] PID_SOF   = 2'b01;
    localparam logic [1:0] PID_IN    = 2'b10;
    localparam logic [1:0] PID_SETUP = 2'b11;

    // Handshake PID[3:2] values
    localparam logic [1:0] HSK_ACK   = 2'b00;
    localparam logic [1:0] HSK_NYET  = 2'b01;
    localparam logic [1:0] HSK_NAK   = 2'b10;
    localparam logic [1:0] HSK_STALL = 2'b11;

    // Result codes
    localparam logic [2:0] RES_OK       = 3'd0;
    localparam logic [2:0] RES_NAK      = 3'd1;
    localparam logic [2:0] RES_STALL    = 3'd2;
    localparam logic [2:0] RES_NYET     = 3'd3;
    localparam logic [2:0] RES_TIMEOUT  = 3'd4;
    localparam logic [2:0] RES_CRC      = 3'd5;
    localparam logic [2:0] RES_TOGGLE   = 3'd6;
    localparam logic [2:0] RES_PROTOCOL = 3'd7;

    // Last counter value of the response window; expiry is flagged in that cycle
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT - 1);

    // Maps a received handshake PID onto its result code
    function automatic logic [2:0] hsk_result(input logic [1:0] pid);
        case (pid)
            HSK_ACK:   hsk_result = RES_OK;
            HSK_NAK:   hsk_result = RES_NAK;
            HSK_STALL: hsk_result = RES_STALL;
            default:   hsk_result = RES_NYET;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          type_q, type_d;
    logic [6:0]          addr_q, addr_d;
    logic [3:0]          endp_q, endp_d;
    logic                tog_q, tog_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [2:0]          pend_q, pend_d;
    logic [2:0]          result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tok_send_q, tok_send_d;
    logic                trn_tsend_q, trn_tsend_d;
    logic                hsk_send_q, hsk_send_d;

    logic                in_data_tx;
    logic                in_wait_data;

    // Next-state, pending result and registered control outputs
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        addr_d      = addr_q;
        endp_d      = endp_q;
        tog_d       = tog_q;
        cnt_d       = '0;
        pend_d      = pend_q;

        case (state_q)
            S_IDLE: begin
                if (xfer.xfer_start_i && (xfer.xfer_type_i != PID_SOF)) begin
                    type_d  = xfer.xfer_type_i;
                    addr_d  = xfer.xfer_addr_i;
                    endp_d  = xfer.xfer_endp_i;
                    tog_d   = xfer.xfer_toggle_i;
                    state_d = S_TOKEN;
                end
            end
            S_TOKEN: begin
                if (tok_done_i) begin
                    state_d = (type_q == PID_IN) ? S_WAIT_DATA : S_DATA_TX;
                end
            end
            S_DATA_TX: begin
                if (trn_tdone_i) begin
                    state_d = S_WAIT_HSK;
                end
            end
            S_WAIT_HSK: begin
                cnt_d = cnt_q + CNT_BITS'(1);
                // A response in the expiry cycle takes priority over the timeout
                if (hsk_recv_i) begin
                    pend_d  = hsk_result(hsk_type_i);
                    state_d = S_DONE;
                end else if (usb_recv_i) begin
                    pend_d  = RES_PROTOCOL;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    pend_d  = RES_TIMEOUT;
                    state_d = S_DONE;
                end
            end
            S_WAIT_DATA: begin
                cnt_d = cnt_q + CNT_BITS'(1);
                if (usb_recv_i) begin
                    if (crc_err_i) begin
                        // Corrupted data is never acknowledged
                        pend_d  = RES_CRC;
                        state_d = S_DONE;
                    end else begin
                        // Good CRC is ACKed even on a toggle mismatch
                        pend_d  = (usb_type_i == {tog_q, 1'b0}) ? RES_OK : RES_TOGGLE;
                        state_d = S_SEND_ACK;
                    end
                end else if (hsk_recv_i) begin
                    case (hsk_type_i)
                        HSK_NAK:   pend_d = RES_NAK;
                        HSK_STALL: pend_d = RES_STALL;
                        default:   pend_d = RES_PROTOCOL;
                    endcase
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    pend_d  = RES_TIMEOUT;
                    state_d = S_DONE;
                end
            end
            S_SEND_ACK: begin
                if (hsk_sent_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Control outputs follow the upcoming state so they come out registered
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        tok_send_d  = (state_d == S_TOKEN);
        trn_tsend_d = (state_d == S_DATA_TX);
        hsk_send_d  = (state_d == S_SEND_ACK);
        result_d    = (state_d == S_DONE) ? pend_d : result_q;
    end

    // Control state and registered control outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_q      <= RES_OK;
            result_q    <= RES_OK;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tok_send_q  <= 1'b0;
            trn_tsend_q <= 1'b0;
            hsk_send_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tok_send_q  <= tok_send_d;
            trn_tsend_q <= trn_tsend_d;
            hsk_send_q  <= hsk_send_d;
        end
    end

    // Latched request fields; only meaningful while a transaction is active
    always_ff @(posedge clock) begin
        type_q <= type_d;
        addr_q <= addr_d;
        endp_q <= endp_d;
        tog_q  <= tog_d;
    end

    assign xfer.xfer_busy_o   = busy_q;
    assign xfer.xfer_done_o   = done_q;
    assign xfer.xfer_result_o = result_q;

    assign tok_send_o  = tok_send_q;
    assign tok_type_o  = type_q;
    assign tok_data_o  = {5'b0, endp_q, addr_q};

    // SETUP data stage always starts with DATA0
    assign trn_tsend_o = trn_tsend_q;
    assign trn_ttype_o = (type_q == PID_SETUP) ? 2'b00 : {tog_q, 1'b0};

    assign hsk_send_o  = hsk_send_q;
    assign hsk_type_o  = HSK_ACK;

    // Payload paths are steered by the registered state only
    assign in_data_tx   = (state_q == S_DATA_TX);
    assign in_wait_data = (state_q == S_WAIT_DATA);

    assign enc_tvalid = in_data_tx & s_tvalid;
    assign enc_tlast  = s_tlast;
    assign enc_tdata  = s_tdata;
    assign s_tready   = in_data_tx & enc_tready;

    // Outside WAIT_DATA the decoder is drained so stray packets never stall it
    assign m_tvalid   = in_wait_data & dec_tvalid;
    assign m_tlast    = dec_tlast;
    assign m_tdata    = dec_tdata;
    assign dec_tready = in_wait_data ? m_tready : 1'b1;

endmodule
